frame_sync_gate: RTL

FRAME_SYNC_GATE -- requirements
Module: frame_sync_gate

---
 rtl/stream_sync_pkg.sv | 20 ++
 rtl/edge_detect_fval.sv | 27 ++
 rtl/frame_sync_gate.sv | 110 +++++++++++
 3 files changed

// File: rtl/stream_sync_pkg.sv
// Shared definitions for the stream synchronisation blocks.
//   sync_state_e : gate FSM state encoding
//   FRAME_CNT_W  : width of the passed-frame counter
package stream_sync_pkg;

  // state       | meaning
  // ST_IDLE     | disabled, nothing passes
  // ST_WAIT_GAP | enabled but a frame was already running; wait for fval low
  // ST_ARMED    | enabled, in a frame gap, next frame start is accepted
  // ST_ACTIVE   | passing the current frame through to the outputs
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GAP = 2'd1,
    ST_ARMED    = 2'd2,
    ST_ACTIVE   = 2'd3
  } sync_state_e;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/edge_detect_fval.sv
// Frame-valid edge detector.
//   clk_pix, reset_pix_n : pixel clock, async active-low reset
//   i_fval               : frame valid input
//   o_fval_r             : i_fval delayed one clock
//   o_frame_start        : i_fval rising this cycle
//   o_frame_end          : i_fval falling this cycle
module edge_detect_fval (
  input  logic clk_pix,
  input  logic reset_pix_n,
  input  logic i_fval,
  output logic o_fval_r,
  output logic o_frame_start,
  output logic o_frame_end
);

  logic fval_q;

  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) fval_q <= 1'b0;
    else              fval_q <= i_fval;
  end

  assign o_fval_r      = fval_q;
  assign o_frame_start = i_fval & ~fval_q;
  assign o_frame_end   = ~i_fval & fval_q;

endmodule

// File: rtl/frame_sync_gate.sv
// Frame-synchronous stream gate. Only whole frames pass: a frame already in
// flight when the gate is enabled is skipped, and a disable during a passed
// frame takes effect only after that frame ends.
//   clk_pix, reset_pix_n        : pixel clock, async active-low reset
//   i_fval, i_lval, iv_pix_data : incoming video timing and pixels
//   i_acquisition_start, i_stream_enable, i_encrypt_state : enable terms
//   iv_pixel_format             : live pixel format register
//   o_fval, o_lval, ov_pix_data : gated video, one clock behind the inputs
//   ov_pixel_format             : format captured at accepted frame start
//   o_full_frame_state          : high while a passed frame is on the output
//   ov_frame_cnt                : number of passed frames (wraps)
module frame_sync_gate
  import stream_sync_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32
) (
  input  logic                                  clk_pix,
  input  logic                                  reset_pix_n,
  input  logic                                  i_fval,
  input  logic                                  i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                  i_acquisition_start,
  input  logic                                  i_stream_enable,
  input  logic                                  i_encrypt_state,
  input  logic [REG_WD-1:0]                     iv_pixel_format,
  output logic                                  o_fval,
  output logic                                  o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [REG_WD-1:0]                     ov_pixel_format,
  output logic                                  o_full_frame_state,
  output logic [FRAME_CNT_W-1:0]                ov_frame_cnt
);

  localparam int DW = SENSOR_DAT_WIDTH * CHANNEL_NUM;

  logic enable;
  logic fval_r, frame_start, frame_end;
  logic accept_start, frame_done;

  sync_state_e            state_q, state_d;
  logic                   lval_q;
  logic [DW-1:0]          pix_q;
  logic [REG_WD-1:0]      fmt_q;
  logic [FRAME_CNT_W-1:0] cnt_q;

  assign enable = i_acquisition_start & i_stream_enable & i_encrypt_state;

  edge_detect_fval u_edge_detect_fval (
    .clk_pix       (clk_pix),
    .reset_pix_n   (reset_pix_n),
    .i_fval        (i_fval),
    .o_fval_r      (fval_r),
    .o_frame_start (frame_start),
    .o_frame_end   (frame_end)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = i_fval ? ST_WAIT_GAP : ST_ARMED;
      end
      ST_WAIT_GAP: begin
        if (!enable)      state_d = ST_IDLE;
        else if (!i_fval) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable)          state_d = ST_IDLE;
        else if (frame_start) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // enable is only looked at once the frame has finished
        if (frame_end) state_d = enable ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept_start = (state_q == ST_ARMED) && (state_d == ST_ACTIVE);
  assign frame_done   = (state_q == ST_ACTIVE) && frame_end;

  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      state_q <= ST_IDLE;
      lval_q  <= 1'b0;
      pix_q   <= '0;
      fmt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lval_q  <= i_lval;
      pix_q   <= iv_pix_data;
      if (accept_start) fmt_q <= iv_pixel_format;
      if (frame_done)   cnt_q <= cnt_q + 1'b1;
    end
  end

  // fval_r and state_q are both registered, so the gated timing lines up
  // with the one-clock-delayed lval/pixel registers. A frame entering
  // ACTIVE this cycle shows up on the next clock, together with its data.
  assign o_fval             = fval_r & (state_q == ST_ACTIVE);
  assign o_lval             = o_fval & lval_q;
  assign ov_pix_data        = o_lval ? pix_q : '0;
  assign ov_pixel_format    = fmt_q;
  assign o_full_frame_state = o_fval;
  assign ov_frame_cnt       = cnt_q;

endmodule
